acumulator_produs: RTL and testbench

- Pipeline stage directly downstream of the product multiplier.
- Consumes one product per accepted handshake and accumulates N consecutive products into a dot-product sum.
- Presents the registered sum to the next stage with a valid/ready handshake.
- Stalls its input while a finished sum is waiting to be taken.

---
 rtl/acumulator_produs_if.sv | 28 ++
 rtl/acumulator_produs.sv | 112 +++++++++++
 tb/tb_acumulator_produs.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acumulator_produs_if.sv
// Handshake bundle between the product multiplier, the accumulator stage and
// the downstream consumer of finished dot-product sums.
interface acumulator_produs_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned CW    = $clog2(N + 1)
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     produs;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] suma;
  logic             overflow;
  logic [CW-1:0]    count;

  modport master (
    output clr, in_valid, produs, out_ready,
    input  in_ready, out_valid, suma, overflow, count
  );

  modport slave (
    input  clr, in_valid, produs, out_ready,
    output in_ready, out_valid, suma, overflow, count
  );
endinterface

// File: rtl/acumulator_produs.sv
// Accumulates N consecutive unsigned products into a registered dot-product
// sum and hands it downstream over valid/ready, stalling input while it waits.
module acumulator_produs #(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned N     = 4
) (
  input  logic                clk,
  input  logic                rst,
  acumulator_produs_if.slave  bus
);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = ACC_W + 1;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_ovf_int;
  logic [ACC_W-1:0] r_suma;
  logic             r_overflow;
  logic             r_out_valid;

  state_t           w_state_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_ovf_int_nxt;
  logic [ACC_W-1:0] w_suma_nxt;
  logic             w_overflow_nxt;
  logic             w_out_valid_nxt;
  logic             w_in_ready;
  logic [W-1:0]     w_produs;
  logic [SW-1:0]    w_sum;

  assign w_produs = bus.produs;
  // One extra bit captures the carry out of the accumulator width.
  assign w_sum    = SW'(r_acc) + SW'(w_produs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf_int   <= 1'b0;
      r_suma      <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_ovf_int   <= w_ovf_int_nxt;
      r_suma      <= w_suma_nxt;
      r_overflow  <= w_overflow_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_count_nxt     = r_count;
    w_ovf_int_nxt   = r_ovf_int;
    w_suma_nxt      = r_suma;
    w_overflow_nxt  = r_overflow;
    w_out_valid_nxt = r_out_valid;
    w_in_ready      = 1'b0;

    case (r_state)
      S_ACC: begin
        // Ready never looks at in_valid, so upstream can rely on it combinationally.
        w_in_ready = !bus.clr;
        if (bus.clr) begin
          w_acc_nxt     = '0;
          w_count_nxt   = '0;
          w_ovf_int_nxt = 1'b0;
        end else if (bus.in_valid) begin
          if (r_count == CW'(N - 1)) begin
            w_suma_nxt      = w_sum[ACC_W-1:0];
            w_overflow_nxt  = r_ovf_int | w_sum[ACC_W];
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_count_nxt     = '0;
            w_ovf_int_nxt   = 1'b0;
            w_state_nxt     = S_DONE;
          end else begin
            w_acc_nxt     = w_sum[ACC_W-1:0];
            w_count_nxt   = r_count + CW'(1);
            w_ovf_int_nxt = r_ovf_int | w_sum[ACC_W];
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_ACC;
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.suma      = r_suma;
  assign bus.overflow  = r_overflow;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_acumulator_produs.sv
// Directed bench for acumulator_produs: a 32-bit accumulator instance for the
// main scenarios and a 17-bit one to exercise carry-out reporting.
module tb_acumulator_produs;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  acumulator_produs_if #(.W(16), .ACC_W(32), .N(4)) b32 ();
  acumulator_produs_if #(.W(16), .ACC_W(17), .N(4)) b17 ();

  acumulator_produs #(.W(16), .ACC_W(32), .N(4)) dut32 (
    .clk(clk), .rst(rst), .bus(b32)
  );
  acumulator_produs #(.W(16), .ACC_W(17), .N(4)) dut17 (
    .clk(clk), .rst(rst), .bus(b17)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product to the selected instance and wait (bounded) until it is taken.
  task automatic push(input bit sel, input logic [15:0] v);
    int n;
    n = 0;
    if (sel) begin b17.in_valid = 1'b1; b17.produs = v; end
    else     begin b32.in_valid = 1'b1; b32.produs = v; end
    while (!(sel ? b17.in_ready : b32.in_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout sel=%0d value=%0d: in_ready stayed 0, required 1", sel, v);
    end
    tick();
    if (sel) b17.in_valid = 1'b0;
    else     b32.in_valid = 1'b0;
  endtask

  task automatic test_reset_idle();
    rst = 1'b1;
    b32.clr = 1'b0; b32.in_valid = 1'b0; b32.produs = '0; b32.out_ready = 1'b0;
    b17.clr = 1'b0; b17.in_valid = 1'b0; b17.produs = '0; b17.out_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (b32.suma !== 32'd0 || b32.out_valid !== 1'b0 || b32.overflow !== 1'b0 || b32.count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: suma=%0h ov=%b ovf=%b cnt=%0d, required 0/0/0/0",
               b32.suma, b32.out_valid, b32.overflow, b32.count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (b32.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b, required 1", b32.in_ready);
    end
  endtask

  task automatic test_basic_sum();
    logic [15:0] vals [4];
    vals[0] = 16'd3; vals[1] = 16'd5; vals[2] = 16'd7; vals[3] = 16'd9;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, vals[i]);
      n_checks++;
      if (b32.count !== 3'(i + 1)) begin
        n_fail++; $display("FAIL basic_count_%0d: got %0d, required %0d", i, b32.count, i + 1);
      end
    end
    push(1'b0, vals[3]);
    n_checks++;
    if (b32.out_valid !== 1'b1 || b32.suma !== 32'd24 || b32.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: ov=%b suma=%0d ovf=%b, required 1/24/0",
               b32.out_valid, b32.suma, b32.overflow);
    end
    tick();
    n_checks++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.count !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_after_drain: ov=%b rdy=%b cnt=%0d, required 0/1/0",
               b32.out_valid, b32.in_ready, b32.count);
    end
  endtask

  task automatic test_reset_midstream();
    push(1'b0, 16'd1);
    push(1'b0, 16'd2);
    rst = 1'b1;
    #1;
    n_checks++;
    if (b32.suma !== 32'd0 || b32.out_valid !== 1'b0 || b32.overflow !== 1'b0 || b32.count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: suma=%0d ov=%b ovf=%b cnt=%0d, required 0/0/0/0",
               b32.suma, b32.out_valid, b32.overflow, b32.count);
    end
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (b32.in_ready !== 1'b1 || b32.count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_midstream_release: rdy=%b cnt=%0d, required 1/0", b32.in_ready, b32.count);
    end
  endtask

  task automatic test_backpressure();
    b32.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(1'b0, 16'(i));
    b32.in_valid = 1'b1;
    b32.produs   = 16'd100;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (b32.in_ready !== 1'b0 || b32.suma !== 32'd10 || b32.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: rdy=%b suma=%0d ov=%b, required 0/10/1",
                 i, b32.in_ready, b32.suma, b32.out_valid);
      end
      tick();
    end
    b32.out_ready = 1'b1;
    tick();
    n_checks++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: rdy=%b ov=%b, required 1/0", b32.in_ready, b32.out_valid);
    end
    tick();
    b32.in_valid = 1'b0;
    tick();
    n_checks++;
    if (b32.count !== 3'd1) begin
      n_fail++; $display("FAIL backpressure_single_accept: count=%0d, required 1", b32.count);
    end
    for (int i = 0; i < 3; i++) push(1'b0, 16'd0);
    n_checks++;
    if (b32.out_valid !== 1'b1 || b32.suma !== 32'd100) begin
      n_fail++;
      $display("FAIL backpressure_sum: ov=%b suma=%0d, required 1/100", b32.out_valid, b32.suma);
    end
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) push(1'b0, 16'hFFFF);
    n_checks++;
    if (b32.suma !== 32'h0003FFFC || b32.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_acc32: suma=%h ovf=%b, required 0003fffc/0", b32.suma, b32.overflow);
    end
    tick();
    b17.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 16'hFFFF);
    n_checks++;
    if (b17.out_valid !== 1'b1 || b17.suma !== 17'h1FFFC || b17.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_acc17: ov=%b suma=%h ovf=%b, required 1/1fffc/1",
               b17.out_valid, b17.suma, b17.overflow);
    end
    tick();
    n_checks++;
    if (b17.out_valid !== 1'b0 || b17.overflow !== 1'b1 || b17.suma !== 17'h1FFFC) begin
      n_fail++;
      $display("FAIL ovf_hold_after_drain: ov=%b ovf=%b suma=%h, required 0/1/1fffc",
               b17.out_valid, b17.overflow, b17.suma);
    end
    for (int i = 0; i < 4; i++) push(1'b1, 16'd1);
    n_checks++;
    if (b17.suma !== 17'd4 || b17.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clean_next: suma=%0d ovf=%b, required 4/0", b17.suma, b17.overflow);
    end
    tick();
  endtask

  task automatic test_clear();
    push(1'b0, 16'd10);
    push(1'b0, 16'd20);
    n_checks++;
    if (b32.count !== 3'd2) begin
      n_fail++; $display("FAIL clear_pre_count: got %0d, required 2", b32.count);
    end
    b32.in_valid = 1'b1;
    b32.produs   = 16'd50;
    b32.clr      = 1'b1;
    #1;
    n_checks++;
    if (b32.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_ready: got %b, required 0", b32.in_ready);
    end
    tick();
    b32.clr      = 1'b0;
    b32.in_valid = 1'b0;
    #1;
    n_checks++;
    if (b32.count !== 3'd0 || b32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_after: cnt=%0d rdy=%b, required 0/1", b32.count, b32.in_ready);
    end
    for (int i = 1; i <= 4; i++) push(1'b0, 16'(i));
    n_checks++;
    if (b32.out_valid !== 1'b1 || b32.suma !== 32'd10 || b32.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_sum: ov=%b suma=%0d ovf=%b, required 1/10/0",
               b32.out_valid, b32.suma, b32.overflow);
    end
    tick();
  endtask

  task automatic test_reset_done();
    b32.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 16'd5);
    n_checks++;
    if (b32.out_valid !== 1'b1 || b32.suma !== 32'd20) begin
      n_fail++;
      $display("FAIL rstdone_pre: ov=%b suma=%0d, required 1/20", b32.out_valid, b32.suma);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (b32.out_valid !== 1'b0 || b32.suma !== 32'd0 || b32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstdone_async: ov=%b suma=%0d rdy=%b, required 0/0/1",
               b32.out_valid, b32.suma, b32.in_ready);
    end
    repeat (2) tick();
    rst = 1'b0;
    b32.out_ready = 1'b1;
    tick();
    n_checks++;
    if (b32.out_valid !== 1'b0 || b32.count !== 3'd0 || b32.suma !== 32'd0) begin
      n_fail++;
      $display("FAIL rstdone_no_stale: ov=%b cnt=%0d suma=%0d, required 0/0/0",
               b32.out_valid, b32.count, b32.suma);
    end
    for (int i = 0; i < 4; i++) push(1'b0, 16'd2);
    n_checks++;
    if (b32.out_valid !== 1'b1 || b32.suma !== 32'd8) begin
      n_fail++;
      $display("FAIL rstdone_next_sum: ov=%b suma=%0d, required 1/8", b32.out_valid, b32.suma);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset_idle();
    test_basic_sum();
    test_reset_midstream();
    test_backpressure();
    test_overflow();
    test_clear();
    test_reset_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
